cbus_arbiter: RTL

- Shares one single-beat memory port between the instruction-fetch bus (ibus) and the memory-stage data bus (dbus).
- Requesters see the standard request/response handshake: valid, then addr_ok on acceptance, then data_ok on completion.
- The memory side sees a latched request held stable until completion.
- Sits between the pipeline front end / memory stage and the memory or cache interface.
- Data requests win arbitration, bounded by an instruction anti-starvation counter.

---
 rtl/cbus_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - ibus/dbus arbiter onto a single-beat memory port
//
// Purpose: shares one memory port between instruction fetch (ibus) and the
// memory-stage data bus (dbus). The data bus wins arbitration unless the
// fetch bus has lost STARVE_LIMIT consecutive arbitrations. One transaction
// is in flight at a time, and IDLE always separates two transactions.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ireq_* / iresp_*           fetch request in, accept/completion out
//   dreq_* / dresp_*           data request in, accept/completion out
//   mreq_*                     latched memory request, zero when not active
//   mresp_ready, mresp_data    memory completion and read data
module cbus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ireq_valid,
   input  logic [31:0] ireq_addr,
   output logic        iresp_addr_ok,
   output logic        iresp_data_ok,
   output logic [31:0] iresp_data,
   input  logic        dreq_valid,
   input  logic [31:0] dreq_addr,
   input  logic [2:0]  dreq_size,
   input  logic [3:0]  dreq_strobe,
   input  logic [31:0] dreq_data,
   output logic        dresp_addr_ok,
   output logic        dresp_data_ok,
   output logic [31:0] dresp_data,
   output logic        mreq_valid,
   output logic        mreq_is_write,
   output logic [31:0] mreq_addr,
   output logic [2:0]  mreq_size,
   output logic [3:0]  mreq_strobe,
   output logic [31:0] mreq_data,
   input  logic        mresp_ready,
   input  logic [31:0] mresp_data
);

   // Size is encoded as the byte count (MSIZE1=1, MSIZE2=2, MSIZE4=4).
   localparam logic [2:0] MSIZE4     = 3'd4;
   localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
   localparam logic [3:0] STARVE_MAX = 4'hF;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        is_write_q, is_write_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [3:0]  strobe_q, strobe_d;
   logic [31:0] data_q, data_d;

   logic        grant_i;
   logic        grant_d;
   logic [31:0] rdata;

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      is_write_d    = is_write_q;
      addr_d        = addr_q;
      size_d        = size_q;
      strobe_d      = strobe_q;
      data_d        = data_q;
      grant_i       = 1'b0;
      grant_d       = 1'b0;
      rdata         = 32'h0;
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'h0;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = 32'h0;
      mreq_valid    = 1'b0;
      mreq_is_write = 1'b0;
      mreq_addr     = 32'h0;
      mreq_size     = 3'h0;
      mreq_strobe   = 4'h0;
      mreq_data     = 32'h0;

      case (state_q)
         IDLE: begin
            grant_i = ireq_valid & (~dreq_valid | (starve_q >= LIMIT));
            grant_d = dreq_valid & ~grant_i;
            // Handshakes are suppressed under reset: the grant would be lost.
            iresp_addr_ok = grant_i & ~reset;
            dresp_addr_ok = grant_d & ~reset;
            if (grant_i) begin
               state_d    = SERVE_I;
               is_write_d = 1'b0;
               addr_d     = ireq_addr;
               size_d     = MSIZE4;
               strobe_d   = 4'h0;
               data_d     = 32'h0;
               starve_d   = 4'h0;
            end else if (grant_d) begin
               state_d    = SERVE_D;
               is_write_d = |dreq_strobe;
               addr_d     = dreq_addr;
               size_d     = dreq_size;
               strobe_d   = dreq_strobe;
               data_d     = dreq_data;
               if (ireq_valid && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         SERVE_I, SERVE_D: begin
            mreq_valid    = 1'b1;
            mreq_is_write = is_write_q;
            mreq_addr     = addr_q;
            mreq_size     = size_q;
            mreq_strobe   = strobe_q;
            mreq_data     = data_q;
            if (mresp_ready) begin
               state_d = IDLE;
            end
            // A reset in the completion cycle abandons the transaction.
            if (mresp_ready && !reset) begin
               rdata = is_write_q ? 32'h0 : mresp_data;
               if (state_q == SERVE_I) begin
                  iresp_data_ok = 1'b1;
                  iresp_data    = rdata;
               end else begin
                  dresp_data_ok = 1'b1;
                  dresp_data    = rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         starve_q   <= 4'h0;
         is_write_q <= 1'b0;
         addr_q     <= 32'h0;
         size_q     <= 3'h0;
         strobe_q   <= 4'h0;
         data_q     <= 32'h0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         strobe_q   <= strobe_d;
         data_q     <= data_d;
      end
   end

endmodule
